// File: rtl/ibex_rf_sram_pkg.sv
// Shared types and constants for the register-file SRAM access scheduler.
package ibex_rf_sram_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned L1Base    = 12;
  localparam int unsigned L1Size    = 4;

  typedef enum logic [1:0] {StIdle, StRdB, StResp} state_e;

  // Where a read lane takes its data from when the response is delivered.
  typedef enum logic [1:0] {SrcKeep, SrcSram, SrcTmp} lane_src_e;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } wbuf_entry_t;

  // x0 and the L1 window are never held in the SRAM.
  function automatic logic needs_sram(logic [4:0] addr);
    return (addr != 5'd0) && !((addr >= 5'(L1Base)) && (addr < 5'(L1Base + L1Size)));
  endfunction

endpackage

// File: rtl/ibex_rf_wbuf.sv
// One-entry SRAM write buffer: accepts SRAM-bound writes, coalesces same-address
// writes, frees on drain and reports address matches for read forwarding.
module ibex_rf_wbuf
  import ibex_rf_sram_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 drain_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 valid_o,
  output logic [4:0]           addr_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 wr_ok_o,
  output logic                 coalesce_o,
  output logic                 hit_a_o,
  output logic                 hit_b_o
);

  wbuf_entry_t entry_q, entry_d;

  always_comb begin
    wr_ok_o    = we_i && needs_sram(waddr_i);
    coalesce_o = wr_ok_o && entry_q.valid && (entry_q.addr == waddr_i);
    hit_a_o    = entry_q.valid && (entry_q.addr == raddr_a_i);
    hit_b_o    = entry_q.valid && (entry_q.addr == raddr_b_i);
    valid_o    = entry_q.valid;
    addr_o     = entry_q.addr;
    data_o     = entry_q.data;
  end

  // A new write always wins: it either coalesces or refills the slot a drain frees.
  always_comb begin
    entry_d = entry_q;
    if (wr_ok_o) begin
      entry_d.valid = 1'b1;
      entry_d.addr  = waddr_i;
      entry_d.data  = wdata_i;
    end else if (drain_i) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/ibex_rf_sram_sched.sv
// Schedules ID-stage operand reads and write-backs onto the dual-port register
// SRAM, forwarding from a one-entry write buffer and stalling on outstanding data.
module ibex_rf_sram_sched
  import ibex_rf_sram_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic                 use_b_i,
  input  logic                 we_i,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 stall_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic [4:0]           sram_a1_o,
  output logic [4:0]           sram_a2_o,
  output logic                 sram_web2_o,
  output logic [DataWidth-1:0] sram_i2_o,
  input  logic [DataWidth-1:0] sram_o1_i,
  input  logic [DataWidth-1:0] sram_o2_i,
  output logic                 wbuf_valid_o,
  output logic [31:0]          miss_cnt_o
);

  state_e                 state_q, state_d;
  lane_src_e              src_a_q, src_a_d, src_b_q, src_b_d;
  logic [DataWidth-1:0]   tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic [DataWidth-1:0]   rdata_a_q, rdata_b_q;
  logic [4:0]             addr_b_q, addr_b_d;
  logic                   fast_q, fast_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;

  logic                   wb_valid, wb_wr_ok, wb_coalesce, wb_hit_a, wb_hit_b, drain;
  logic [4:0]             wb_addr;
  logic [DataWidth-1:0]   wb_data;
  logic                   miss_a, miss_b, fwd_a, fwd_b, rd_a, rd_b, rd_b_now, drain_forced;

  ibex_rf_wbuf u_wbuf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .drain_i    (drain),
    .raddr_a_i  (raddr_a_i),
    .raddr_b_i  (raddr_b_i),
    .valid_o    (wb_valid),
    .addr_o     (wb_addr),
    .data_o     (wb_data),
    .wr_ok_o    (wb_wr_ok),
    .coalesce_o (wb_coalesce),
    .hit_a_o    (wb_hit_a),
    .hit_b_o    (wb_hit_b)
  );

  function automatic logic [DataWidth-1:0] pick(lane_src_e src, logic [DataWidth-1:0] sram,
                                                logic [DataWidth-1:0] tmp,
                                                logic [DataWidth-1:0] hold);
    case (src)
      SrcSram: return sram;
      SrcTmp:  return tmp;
      default: return hold;
    endcase
  endfunction

  always_comb begin
    miss_a       = needs_sram(raddr_a_i);
    miss_b       = use_b_i && needs_sram(raddr_b_i);
    fwd_a        = miss_a && wb_hit_a;
    fwd_b        = miss_b && wb_hit_b;
    rd_a         = req_i && (state_q == StIdle) && miss_a && !wb_hit_a;
    rd_b         = req_i && (state_q == StIdle) && miss_b && !wb_hit_b;
    rd_b_now     = rd_b || (state_q == StRdB);
    drain_forced = wb_valid && wb_wr_ok && !wb_coalesce;
    // Coalescing keeps the entry in place; otherwise drain unless read B owns port 2.
    drain        = wb_valid && !wb_coalesce && (wb_wr_ok || !rd_b_now);
  end

  always_comb begin
    sram_a1_o   = rd_a ? raddr_a_i : 5'd0;
    sram_a2_o   = 5'd0;
    sram_web2_o = 1'b1;
    sram_i2_o   = '0;
    if (drain) begin
      sram_a2_o   = wb_addr;
      sram_web2_o = 1'b0;
      sram_i2_o   = wb_data;
    end else if (rd_b_now) begin
      sram_a2_o = (state_q == StRdB) ? addr_b_q : raddr_b_i;
    end
  end

  always_comb begin
    rvalid_o  = (state_q == StResp) || fast_q;
    rdata_a_o = rvalid_o ? pick(src_a_q, sram_o1_i, tmp_a_q, rdata_a_q) : rdata_a_q;
    rdata_b_o = rvalid_o ? pick(src_b_q, sram_o2_i, tmp_b_q, rdata_b_q) : rdata_b_q;
  end

  always_comb begin
    state_d    = state_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    tmp_a_d    = tmp_a_q;
    tmp_b_d    = tmp_b_q;
    addr_b_d   = addr_b_q;
    fast_d     = 1'b0;
    miss_cnt_d = miss_cnt_q;
    stall_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          src_a_d  = rd_a ? SrcSram : (fwd_a ? SrcTmp : SrcKeep);
          src_b_d  = rd_b ? SrcSram : (fwd_b ? SrcTmp : SrcKeep);
          tmp_a_d  = fwd_a ? wb_data : tmp_a_q;
          tmp_b_d  = fwd_b ? wb_data : tmp_b_q;
          addr_b_d = raddr_b_i;
          if (rd_a || rd_b) begin
            stall_o    = 1'b1;
            miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 32'd1;
            state_d    = (rd_b && drain_forced) ? StRdB : StResp;
          end else begin
            fast_d = 1'b1;
          end
        end
      end
      StRdB: begin
        stall_o = 1'b1;
        // Port-1 data is only valid in the first RD_B cycle; park it in tmp.
        if (src_a_q == SrcSram) begin
          tmp_a_d = sram_o1_i;
          src_a_d = SrcTmp;
        end
        if (!drain_forced) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      src_a_q    <= SrcKeep;
      src_b_q    <= SrcKeep;
      tmp_a_q    <= '0;
      tmp_b_q    <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      addr_b_q   <= 5'd0;
      fast_q     <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      tmp_a_q    <= tmp_a_d;
      tmp_b_q    <= tmp_b_d;
      rdata_a_q  <= rdata_a_o;
      rdata_b_q  <= rdata_b_o;
      addr_b_q   <= addr_b_d;
      fast_q     <= fast_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign wbuf_valid_o = wb_valid;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_ibex_rf_sram_sched.sv
// Directed bench for ibex_rf_sram_sched with a behavioural dual-port SRAM.
module tb_ibex_rf_sram_sched;

  logic        clk, rst_ni, req, use_b, we;
  logic [4:0]  ra, rb, wa;
  logic [31:0] wd;
  logic        stall, rvalid, web2, wbuf_valid;
  logic [31:0] rdata_a, rdata_b, i2, o1, o2, miss_cnt;
  logic [4:0]  a1, a2;

  logic [31:0] mem [32];
  int          n_wr8;
  int          n_err;
  int          n_chk;

  ibex_rf_sram_sched dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req),
    .raddr_a_i    (ra),
    .raddr_b_i    (rb),
    .use_b_i      (use_b),
    .we_i         (we),
    .waddr_i      (wa),
    .wdata_i      (wd),
    .stall_o      (stall),
    .rvalid_o     (rvalid),
    .rdata_a_o    (rdata_a),
    .rdata_b_o    (rdata_b),
    .sram_a1_o    (a1),
    .sram_a2_o    (a2),
    .sram_web2_o  (web2),
    .sram_i2_o    (i2),
    .sram_o1_i    (o1),
    .sram_o2_i    (o2),
    .wbuf_valid_o (wbuf_valid),
    .miss_cnt_o   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dual-port SRAM, one-cycle read latency.
  always @(posedge clk) begin
    o1 <= mem[a1];
    if (!web2) begin
      mem[a2] <= i2;
      if (a2 == 5'd8) n_wr8 = n_wr8 + 1;
    end else begin
      o2 <= mem[a2];
    end
  end

  typedef struct {
    logic [4:0]  ra, rb;
    logic        ub;
    logic        exp_stall;
    logic [4:0]  exp_a1, exp_a2;
    logic [31:0] exp_a, exp_b, exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] xa, input logic [4:0] xb,
                       input logic ub, input logic w, input logic [4:0] xw,
                       input logic [31:0] d);
    req = r; ra = xa; rb = xb; use_b = ub; we = w; wa = xw; wd = d;
  endtask

  task automatic next_idle();
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
  endtask

  initial begin
    n_err = 0; n_chk = 0; n_wr8 = 0;
    o1 = '0; o2 = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    mem[5] = 32'h11;
    mem[7] = 32'h22;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    rst_ni = 1'b0;

    vecs[0] = '{5'd5,  5'd7,  1'b1, 1'b1, 5'd5,  5'd7,  32'h11,  32'h22,  32'd1};
    vecs[1] = '{5'd13, 5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  32'h11,  32'h22,  32'd1};
    vecs[2] = '{5'd0,  5'd20, 1'b0, 1'b0, 5'd0,  5'd0,  32'h11,  32'h22,  32'd1};
    vecs[3] = '{5'd20, 5'd12, 1'b1, 1'b1, 5'd20, 5'd0,  32'h114, 32'h22,  32'd2};
    vecs[4] = '{5'd15, 5'd31, 1'b1, 1'b1, 5'd0,  5'd31, 32'h114, 32'h11F, 32'd3};
    vecs[5] = '{5'd11, 5'd16, 1'b1, 1'b1, 5'd11, 5'd16, 32'h10B, 32'h110, 32'd4};

    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rst_stall", stall, 0);       chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata_a", rdata_a, 0);   chk("rst_rdata_b", rdata_b, 0);
    chk("rst_a1", a1, 0);             chk("rst_a2", a2, 0);
    chk("rst_web2", web2, 1);         chk("rst_i2", i2, 0);
    chk("rst_cnt", miss_cnt, 0);      chk("rst_wbuf", wbuf_valid, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].ra, vecs[i].rb, vecs[i].ub, 1'b0, 5'd0, 32'd0);
      #1;
      chk($sformatf("v%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("v%0d_a1", i), a1, vecs[i].exp_a1);
      chk($sformatf("v%0d_a2", i), a2, vecs[i].exp_a2);
      next_idle();
      chk($sformatf("v%0d_rvalid", i), rvalid, 1);
      chk($sformatf("v%0d_stall1", i), stall, 0);
      chk($sformatf("v%0d_rdata_a", i), rdata_a, vecs[i].exp_a);
      chk($sformatf("v%0d_rdata_b", i), rdata_b, vecs[i].exp_b);
      chk($sformatf("v%0d_cnt", i), miss_cnt, vecs[i].exp_cnt);
      next_idle();
      chk($sformatf("v%0d_rvalid2", i), rvalid, 0);
    end

    // Write x9 then read it back through the buffer.
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 32'hAB);
    #1;
    chk("fwd_pre_web2", web2, 1);
    @(negedge clk);
    drive(1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("fwd_stall", stall, 0);       chk("fwd_a1", a1, 0);
    chk("fwd_web2", web2, 0);         chk("fwd_a2", a2, 9);
    chk("fwd_i2", i2, 32'hAB);
    next_idle();
    chk("fwd_rvalid", rvalid, 1);     chk("fwd_rdata_a", rdata_a, 32'hAB);
    chk("fwd_rdata_b", rdata_b, 32'h110);
    chk("fwd_cnt", miss_cnt, 4);      chk("fwd_wbuf", wbuf_valid, 0);
    chk("fwd_mem9", mem[9], 32'hAB);

    // Read B displaced by a forced drain.
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h33);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd4, 1'b1, 1'b1, 5'd6, 32'h5);
    #1;
    chk("disp_stall0", stall, 1);     chk("disp_a2_0", a2, 3);
    chk("disp_web2_0", web2, 0);      chk("disp_i2_0", i2, 32'h33);
    next_idle();
    chk("disp_stall1", stall, 1);     chk("disp_rvalid1", rvalid, 0);
    chk("disp_a2_1", a2, 4);          chk("disp_web2_1", web2, 1);
    chk("disp_wbuf1", wbuf_valid, 1);
    next_idle();
    chk("disp_rvalid2", rvalid, 1);   chk("disp_stall2", stall, 0);
    chk("disp_rdata_b", rdata_b, 32'h104);
    chk("disp_rdata_a", rdata_a, 32'hAB);
    chk("disp_a2_2", a2, 6);          chk("disp_web2_2", web2, 0);
    chk("disp_i2_2", i2, 32'h5);      chk("disp_cnt", miss_cnt, 5);
    next_idle();
    chk("disp_mem3", mem[3], 32'h33); chk("disp_mem6", mem[6], 32'h5);
    chk("disp_wbuf3", wbuf_valid, 0);

    // Back-to-back writes to x8 coalesce into one drain.
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd20, 1'b1, 1'b1, 5'd8, 32'h1);
    #1;
    chk("coal_stall", stall, 1);      chk("coal_a2_0", a2, 20);
    chk("coal_web2_0", web2, 1);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd8, 32'h2);
    #1;
    chk("coal_rvalid", rvalid, 1);    chk("coal_rdata_b", rdata_b, 32'h114);
    chk("coal_web2_1", web2, 1);      chk("coal_cnt", miss_cnt, 6);
    next_idle();
    chk("coal_web2_2", web2, 0);      chk("coal_a2_2", a2, 8);
    chk("coal_i2_2", i2, 32'h2);
    next_idle();
    chk("coal_nwr8", n_wr8, 1);       chk("coal_mem8", mem[8], 32'h2);
    chk("coal_wbuf", wbuf_valid, 0);

    // Reset while in RD_B.
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h44);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd4, 1'b1, 1'b1, 5'd6, 32'h7);
    #1;
    chk("rrb_stall0", stall, 1);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("rrb_stall", stall, 0);       chk("rrb_rvalid", rvalid, 0);
    chk("rrb_rdata_a", rdata_a, 0);   chk("rrb_rdata_b", rdata_b, 0);
    chk("rrb_a2", a2, 0);             chk("rrb_web2", web2, 1);
    chk("rrb_i2", i2, 0);             chk("rrb_wbuf", wbuf_valid, 0);
    chk("rrb_cnt", miss_cnt, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    chk("rst2_stall", stall, 1);
    next_idle();
    chk("rst2_rvalid", rvalid, 1);    chk("rst2_rdata_a", rdata_a, 32'h11);
    chk("rst2_rdata_b", rdata_b, 32'h22);
    chk("rst2_cnt", miss_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_rf_sram_sched.md
# ibex_rf_sram_sched

Access scheduler between the ID-stage register-file read/write requests and the dual-port 32x32 register SRAM (port 1 read-only, port 2 read/write, both synchronous with one-cycle read latency). It issues SRAM reads for operands outside the L1 window (x12–x15) and x0, and buffers SRAM-bound writes in a one-entry write buffer. It drains that buffer into free port-2 slots, forwards buffered data to reads, and raises the core stall while operand data is outstanding. A saturating counter reports how many requests stalled.

## Interface
- DataWidth, 32, register width
- L1Base, 12, first register held in L1 (x12); L1 window is L1Base..L1Base+3

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  single-cycle pulse, new instruction operands valid; ignored unless state is IDLE
- raddr_a_i  in  5  rs1 address
- raddr_b_i  in  5  rs2 address
- use_b_i  in  1  rs2 is used (0 for immediate instructions)
- we_i  in  1  write-back request, any state
- waddr_i  in  5  write address
- wdata_i  in  DataWidth  write data
- stall_o  out  1  core must hold ID stage
- rvalid_o  out  1  one-cycle pulse, SRAM operand data on rdata_*_o
- rdata_a_o / rdata_b_o  out  DataWidth  operand data, held between pulses
- sram_a1_o / sram_a2_o  out  5  SRAM port 1 / port 2 address
- sram_web2_o  out  1  port-2 write enable, active-low
- sram_i2_o  out  DataWidth  port-2 write data
- sram_o1_i / sram_o2_i  in  DataWidth  SRAM read data, valid the cycle after the address
- wbuf_valid_o  out  1  write buffer occupied
- miss_cnt_o  out  32  count of stalled requests, saturating

## Operation
- Operand X needs SRAM (miss_X) when its address ≠ 0 and is outside the L1 window. B additionally requires use_b_i=1.
- If the address of a missing operand equals the buffered write address while wbuf is valid, the operand is forwarded. The data is captured from the buffer in cycle N and no SRAM read is issued.
- Writes with waddr 0 or inside the L1 window are ignored. Other writes go into the buffer at the end of the cycle.
- A write to the same address as the buffered entry coalesces: data is replaced and no drain occurs.
- Port 1 always carries read A in the request cycle.
- Port 2 priority: (1) drain when wbuf is full and a new SRAM-bound write arrives in the same cycle; (2) read B; (3) drain when wbuf is valid.
- A drain frees the entry. A simultaneous new write refills it.
- A write in cycle N is not visible to a read issued in cycle N. The read returns the older SRAM or buffer value.
- FSM states:
  - IDLE: on req_i with any unforwarded miss, go to RESP. If read B is displaced by priority (1), go to RD_B instead.
  - RD_B: issue B on port 2, capture A from sram_o1_i, then go to RESP.
  - RESP: drive data and pulse rvalid_o, then go to IDLE.
- A request whose misses are all forwarded, or that has no misses, does not stall. It pulses rvalid_o in cycle N+1 with the forwarded data.
- miss_cnt_o increments by 1 for each request that asserts stall_o, and holds at 0xFFFF_FFFF.
- sram_web2_o is 1 whenever no drain occurs. Idle addresses are 0.

## Timing
- Reset values:
  - state IDLE, wbuf invalid
  - stall_o=0, rvalid_o=0, rdata_*_o=0
  - sram_a*_o=0, sram_web2_o=1, sram_i2_o=0
  - miss_cnt_o=0
- Reset asserted mid-sequence aborts the sequence immediately. The buffered write is lost, and the core restarts the sequence.
- Normal miss: stall_o=1 combinationally in N (req cycle). In N+1 (RESP), stall_o=0, rvalid_o=1, and rdata_X_o = sram_oX_i or forwarded data.
- Displaced B: stall_o=1 in N and N+1; data is delivered in N+2.
- rdata_*_o registers capture the RESP value and hold it afterwards. Lanes with no miss hold their previous value.
- Buffered write reaches SRAM no earlier than N+1 after its we_i cycle.

## Structure
- Package ibex_rf_sram_pkg holds:
  - the state enum (IDLE, RD_B, RESP)
  - the L1 window constants
  - the write-buffer entry struct {valid, addr[4:0], data}
- One natural sub-module: ibex_rf_wbuf. It is the one-entry buffer with coalesce, drain and address-match forward logic.

## Test plan
- req rs1=x5, rs2=x7, use_b=1, SRAM x5=0x11, x7=0x22: stall_o=1 in N only; rvalid_o in N+1 with a=0x11, b=0x22; miss_cnt_o=1.
- req rs1=x13, rs2=x0: no SRAM read, stall_o=0; rvalid_o in N+1 with rdata unchanged; miss_cnt_o unchanged.
- we x9=0xAB in N-1, req rs1=x9 in N: forwarded, stall_o=0, rdata_a=0xAB in N+1, no port-1 read; x9 drained to SRAM in a later free port-2 cycle.
- wbuf holds x3, and in the same cycle req rs2=x4 (use_b=1) plus we x6=0x5: port 2 writes x3 in N, reads x4 in N+1; stall_o in N and N+1; rvalid_o in N+2; wbuf then holds x6.
- two writes to x8 (0x1 then 0x2) back-to-back with port 2 busy: single drain writes 0x2.
- rst_ni low during RD_B: all outputs return to reset values at once; wbuf_valid_o=0.
